sensor_request_scheduler: RTL and testbench
===========================================

// Module: sensor_request_scheduler
// PURPOSE
//  Sits between uart_rx, conexao_sensor and uart_tx. Sequences one sensor transaction at a time.
//  Arbitrates PC requests against periodic continuous-monitoring reads, with PC requests first.
//  Applies a response timeout and handshakes each response into uart_tx.
// PARAMETERS
//  CLK_HZ          50_000_000  clock frequency, Hz
//  PERIOD_MS       2000        monitoring sample interval, ms (tick every CLK_HZ/1000*PERIOD_MS cycles)
//  TIMEOUT_CYCLES  50_000_000  maximum wait for sensor_done before a timeout response (1 s)
// PORTS
//  clock               in   1  system clock, 50 MHz
//  reset               in   1  synchronous, active-high
//  rx_valid            in   1  1-cycle pulse: rx_command/rx_address valid
//  rx_command          in   8  request command from PC
//  rx_address          in   8  sensor address (0 = DHT11, 1..31 = other sensors)
//  cancel_monitoring   in   1  level, pre-synchronized upstream; high stops monitoring
//  sensor_start        out  1  1-cycle pulse to conexao_sensor
//  sensor_command      out  8  command held stable from sensor_start until sensor_done
//  sensor_address      out  8  address held stable from sensor_start until sensor_done
//  sensor_done         in   1  1-cycle pulse: sensor_resp_* valid
//  sensor_resp_command in   8  response code from sensor path
//  sensor_resp_value   in   8  response data from sensor path
//  tx_start            out  1  1-cycle pulse to uart_tx
//  tx_command          out  8  response code, held until WAIT_TX exits
//  tx_value            out  8  response data, held until WAIT_TX exits
//  tx_busy             in   1  uart_tx transmission in progress
//  monitoring_active   out  1  continuous monitoring enabled
//  overflow            out  1  sticky: a PC request was dropped; cleared by reset only
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM enters IDLE.
//   - pending, mon_due and monitoring are cleared; period counter is 0.
//   - Reset mid-transaction abandons the transaction; no tx_start is issued.
//  Request queue:
//   - rx_valid loads a 1-deep pending register.
//   - rx_valid while pending is full drops the new request and sets overflow.
//  FSM states: IDLE, ISSUE, WAIT_SENSOR, SEND, WAIT_TX.
//  IDLE:
//   - pending is set: take it (priority over monitoring).
//     - CMD_MON_STOP: clear monitoring; respond RSP_MON_OFF/addr, go to SEND, no sensor access.
//     - CMD_MON_TEMP or CMD_MON_HUM: latch it as mon_cmd/mon_addr, set monitoring, clear the
//       period counter, then go to ISSUE with the equivalent read command.
//     - Any other command: go to ISSUE unchanged.
//   - Else if mon_due and monitoring: clear mon_due, go to ISSUE with the mon read.
//  ISSUE:
//   - sensor_start=1 for exactly one cycle, then go to WAIT_SENSOR.
//  WAIT_SENSOR:
//   - sensor_done: capture sensor_resp_*, go to SEND.
//   - Timeout counter reaches TIMEOUT_CYCLES-1: respond RSP_TIMEOUT/addr, go to SEND.
//   - sensor_done in the same cycle as expiry: sensor_done wins.
//  SEND:
//   - Wait for tx_busy==0, then drive tx_start=1 for one cycle and go to WAIT_TX.
//  WAIT_TX:
//   - Ignore tx_busy for the first cycle; uart_tx asserts it within 1 cycle.
//   - Then exit to IDLE when tx_busy==0.
//  Period timer:
//   - Runs only while monitoring is set. Terminal count sets mon_due; ticks do not stack.
//  Monitoring stop:
//   - cancel_monitoring high clears monitoring and mon_due in the same cycle.
//   - A monitoring transaction already in flight completes and is transmitted.
//   - A mon-start request accepted in the same cycle as cancel: cancel wins.
//  Latency: pending request in IDLE -> sensor_start = 2 cycles.
// CONFIGURATION
//  Macro MON_CHANGE_ONLY_EN:
//   - Defined: a monitoring sample whose resp_command/value equals the last transmitted
//     monitoring sample skips SEND and returns to IDLE. Timeouts are always sent.
//     The last-sample register is cleared when monitoring starts.
//   - Undefined: every monitoring sample is transmitted.
//   - PC-initiated responses are unaffected in both cases.
// STRUCTURE
//  Shared include sensor_cmd_defs.vh:
//   - CMD_* codes: CMD_READ_TEMP 8'h01, CMD_READ_HUM 8'h02, CMD_MON_TEMP 8'h03,
//     CMD_MON_HUM 8'h04, CMD_MON_STOP 8'h05.
//   - RSP_* codes: RSP_MON_OFF 8'h0A, RSP_TIMEOUT 8'hFE.
//   - FSM state encodings.
//  Sub-module period_timer(clock, reset, enable, clear, tick) generates mon_due ticks.
// TESTING
//  T1: rx READ_TEMP/00; done 2 cycles later with 0x1B -> one tx_start, tx=0x1B; sensor_start 2 cycles after rx.
//  T2: rx READ_HUM/00; no done -> tx RSP_TIMEOUT/00 after exactly TIMEOUT_CYCLES; FSM returns to IDLE.
//  T3: MON_TEMP/00 with PERIOD_MS=1 -> first read immediately, then one read every 50_000 cycles.
//      cancel_monitoring pulse -> no further sensor_start.
//  T4: two rx pulses during WAIT_SENSOR -> first served after current; second dropped; overflow=1.
//  T5: monitoring tick and rx READ_TEMP pending together -> PC request issued first, mon read next.
//  T6: MON_CHANGE_ONLY_EN with constant sensor value -> exactly one tx per monitoring session;
//      value change -> tx.

Source files
------------

// File: rtl/sensor_request_scheduler_pkg.sv
// Command/response codes and FSM state encoding shared by the sensor request scheduler.
package sensor_request_scheduler_pkg;

  localparam logic [7:0] CMD_READ_TEMP = 8'h01;
  localparam logic [7:0] CMD_READ_HUM  = 8'h02;
  localparam logic [7:0] CMD_MON_TEMP  = 8'h03;
  localparam logic [7:0] CMD_MON_HUM   = 8'h04;
  localparam logic [7:0] CMD_MON_STOP  = 8'h05;

  localparam logic [7:0] RSP_MON_OFF   = 8'h0A;
  localparam logic [7:0] RSP_TIMEOUT   = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_SENSOR = 3'd2,
    ST_SEND        = 3'd3,
    ST_WAIT_TX     = 3'd4
  } state_t;

  function automatic logic is_mon_start(input logic [7:0] cmd);
    return (cmd == CMD_MON_TEMP) || (cmd == CMD_MON_HUM);
  endfunction

  // Monitoring commands map onto the plain read that each periodic sample performs.
  function automatic logic [7:0] mon_read_cmd(input logic [7:0] cmd);
    return (cmd == CMD_MON_HUM) ? CMD_READ_HUM : CMD_READ_TEMP;
  endfunction

endpackage

// File: rtl/sensor_request_scheduler_period_timer.sv
// Monitoring period timer: one-cycle tick every PERIOD_CYCLES enabled cycles.
module sensor_request_scheduler_period_timer #(
  parameter int unsigned PERIOD_CYCLES = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] FIRST = (PERIOD_CYCLES > 1) ? CW'(1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // The clearing cycle counts as the first cycle of the new period, so the
  // first periodic sample lands exactly one period after the starting read.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = FIRST;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sensor_request_scheduler.sv
// Sequences one sensor transaction at a time; PC requests win over periodic monitoring reads.
// Build option MON_CHANGE_ONLY_EN: drop monitoring samples equal to the last one transmitted.
//
// state          | meaning
// ST_IDLE        | arbitrate pending PC request against a due monitoring read
// ST_ISSUE       | one-cycle sensor_start pulse
// ST_WAIT_SENSOR | wait for sensor_done or response timeout
// ST_SEND        | wait for uart_tx idle, then pulse tx_start
// ST_WAIT_TX     | wait for uart_tx to finish the response
module sensor_request_scheduler
  import sensor_request_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned PERIOD_MS      = 2000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_command,
  input  logic [7:0] rx_address,
  input  logic       cancel_monitoring,
  output logic       sensor_start,
  output logic [7:0] sensor_command,
  output logic [7:0] sensor_address,
  input  logic       sensor_done,
  input  logic [7:0] sensor_resp_command,
  input  logic [7:0] sensor_resp_value,
  output logic       tx_start,
  output logic [7:0] tx_command,
  output logic [7:0] tx_value,
  input  logic       tx_busy,
  output logic       monitoring_active,
  output logic       overflow
);

  localparam int unsigned PERIOD_CYCLES = CLK_HZ / 1000 * PERIOD_MS;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [7:0]    pend_cmd_q, pend_cmd_d;
  logic [7:0]    pend_addr_q, pend_addr_d;
  logic          overflow_q, overflow_d;
  logic          monitoring_q, monitoring_d;
  logic          mon_due_q, mon_due_d;
  logic [7:0]    mon_cmd_q, mon_cmd_d;
  logic [7:0]    mon_addr_q, mon_addr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    rsp_cmd_q, rsp_cmd_d;
  logic [7:0]    rsp_val_q, rsp_val_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tx_first_q, tx_first_d;
  logic          period_clear;
  logic          period_tick;
`ifdef MON_CHANGE_ONLY_EN
  logic          is_mon_q, is_mon_d;
  logic          last_valid_q, last_valid_d;
  logic [7:0]    last_cmd_q, last_cmd_d;
  logic [7:0]    last_val_q, last_val_d;
`endif

  sensor_request_scheduler_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_period_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (monitoring_q),
    .clear  (period_clear),
    .tick   (period_tick)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    pend_cmd_d   = pend_cmd_q;
    pend_addr_d  = pend_addr_q;
    overflow_d   = overflow_q;
    monitoring_d = monitoring_q;
    mon_due_d    = mon_due_q;
    mon_cmd_d    = mon_cmd_q;
    mon_addr_d   = mon_addr_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    rsp_cmd_d    = rsp_cmd_q;
    rsp_val_d    = rsp_val_q;
    tx_first_d   = tx_first_q;
    period_clear = 1'b0;
    sensor_start = 1'b0;
    tx_start     = 1'b0;
`ifdef MON_CHANGE_ONLY_EN
    is_mon_d     = is_mon_q;
    last_valid_d = last_valid_q;
    last_cmd_d   = last_cmd_q;
    last_val_d   = last_val_q;
`endif

    tmo_cnt_d = ((state_q == ST_ISSUE) || (state_q == ST_WAIT_SENSOR))
                ? tmo_cnt_q + TW'(1) : '0;

    // A tick coinciding with an already-due sample simply leaves it due.
    if (period_tick) mon_due_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          if (pend_cmd_q == CMD_MON_STOP) begin
            monitoring_d = 1'b0;
            mon_due_d    = 1'b0;
            rsp_cmd_d    = RSP_MON_OFF;
            rsp_val_d    = pend_addr_q;
            state_d      = ST_SEND;
          end else if (is_mon_start(pend_cmd_q)) begin
            mon_cmd_d    = mon_read_cmd(pend_cmd_q);
            mon_addr_d   = pend_addr_q;
            monitoring_d = 1'b1;
            mon_due_d    = 1'b0;
            period_clear = 1'b1;
            cmd_d        = mon_read_cmd(pend_cmd_q);
            addr_d       = pend_addr_q;
`ifdef MON_CHANGE_ONLY_EN
            is_mon_d     = 1'b1;
            last_valid_d = 1'b0;
`endif
            state_d      = ST_ISSUE;
          end else begin
            cmd_d        = pend_cmd_q;
            addr_d       = pend_addr_q;
`ifdef MON_CHANGE_ONLY_EN
            is_mon_d     = 1'b0;
`endif
            state_d      = ST_ISSUE;
          end
        end else if (mon_due_q && monitoring_q) begin
          mon_due_d = 1'b0;
          cmd_d     = mon_cmd_q;
          addr_d    = mon_addr_q;
`ifdef MON_CHANGE_ONLY_EN
          is_mon_d  = 1'b1;
`endif
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        sensor_start = 1'b1;
        state_d      = ST_WAIT_SENSOR;
      end

      ST_WAIT_SENSOR: begin
        if (sensor_done) begin
          state_d   = ST_SEND;
          rsp_cmd_d = sensor_resp_command;
          rsp_val_d = sensor_resp_value;
`ifdef MON_CHANGE_ONLY_EN
          if (is_mon_q) begin
            if (last_valid_q && (last_cmd_q == sensor_resp_command)
                && (last_val_q == sensor_resp_value)) begin
              state_d   = ST_IDLE;
              rsp_cmd_d = rsp_cmd_q;
              rsp_val_d = rsp_val_q;
            end
            last_valid_d = 1'b1;
            last_cmd_d   = sensor_resp_command;
            last_val_d   = sensor_resp_value;
          end
`endif
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_cmd_d = RSP_TIMEOUT;
          rsp_val_d = addr_q;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          tx_first_d = 1'b1;
          state_d    = ST_WAIT_TX;
        end
      end

      ST_WAIT_TX: begin
        if (tx_first_q)    tx_first_d = 1'b0;
        else if (!tx_busy) state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Full means full at this edge, even if IDLE is draining the slot now.
    if (rx_valid) begin
      if (pending_q) begin
        overflow_d = 1'b1;
      end else begin
        pending_d   = 1'b1;
        pend_cmd_d  = rx_command;
        pend_addr_d = rx_address;
      end
    end

    if (cancel_monitoring) begin
      monitoring_d = 1'b0;
      mon_due_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      pend_cmd_q   <= '0;
      pend_addr_q  <= '0;
      overflow_q   <= 1'b0;
      monitoring_q <= 1'b0;
      mon_due_q    <= 1'b0;
      mon_cmd_q    <= '0;
      mon_addr_q   <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      rsp_cmd_q    <= '0;
      rsp_val_q    <= '0;
      tmo_cnt_q    <= '0;
      tx_first_q   <= 1'b0;
`ifdef MON_CHANGE_ONLY_EN
      is_mon_q     <= 1'b0;
      last_valid_q <= 1'b0;
      last_cmd_q   <= '0;
      last_val_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pend_cmd_q   <= pend_cmd_d;
      pend_addr_q  <= pend_addr_d;
      overflow_q   <= overflow_d;
      monitoring_q <= monitoring_d;
      mon_due_q    <= mon_due_d;
      mon_cmd_q    <= mon_cmd_d;
      mon_addr_q   <= mon_addr_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      rsp_cmd_q    <= rsp_cmd_d;
      rsp_val_q    <= rsp_val_d;
      tmo_cnt_q    <= tmo_cnt_d;
      tx_first_q   <= tx_first_d;
`ifdef MON_CHANGE_ONLY_EN
      is_mon_q     <= is_mon_d;
      last_valid_q <= last_valid_d;
      last_cmd_q   <= last_cmd_d;
      last_val_q   <= last_val_d;
`endif
    end
  end

  assign sensor_command    = cmd_q;
  assign sensor_address    = addr_q;
  assign tx_command        = rsp_cmd_q;
  assign tx_value          = rsp_val_q;
  assign monitoring_active = monitoring_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// Directed bench for sensor_request_scheduler with scaled-down period (100 cycles) and timeout (40 cycles).
module tb_sensor_request_scheduler;

  localparam int unsigned CLK_HZ  = 100_000;
  localparam int unsigned PER_MS  = 1;
  localparam int unsigned TMO     = 40;
  localparam int          PERIOD  = 100;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_command;
  logic [7:0] rx_address;
  logic       cancel_monitoring;
  logic       sensor_start;
  logic [7:0] sensor_command;
  logic [7:0] sensor_address;
  logic       sensor_done;
  logic [7:0] sensor_resp_command;
  logic [7:0] sensor_resp_value;
  logic       tx_start;
  logic [7:0] tx_command;
  logic [7:0] tx_value;
  logic       tx_busy;
  logic       monitoring_active;
  logic       overflow;

  sensor_request_scheduler #(
    .CLK_HZ(CLK_HZ), .PERIOD_MS(PER_MS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .rx_valid(rx_valid), .rx_command(rx_command), .rx_address(rx_address),
    .cancel_monitoring(cancel_monitoring),
    .sensor_start(sensor_start), .sensor_command(sensor_command),
    .sensor_address(sensor_address), .sensor_done(sensor_done),
    .sensor_resp_command(sensor_resp_command), .sensor_resp_value(sensor_resp_value),
    .tx_start(tx_start), .tx_command(tx_command), .tx_value(tx_value),
    .tx_busy(tx_busy), .monitoring_active(monitoring_active), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         start_cnt = 0, tx_cnt = 0, start_cyc = 0, tx_cyc = 0;
  logic [7:0] st_cmd_seen = 0, st_addr_seen = 0, tx_cmd_seen = 0, tx_val_seen = 0;

  always @(negedge clock) begin
    if (sensor_start) begin
      start_cnt    <= start_cnt + 1;
      start_cyc    <= cyc;
      st_cmd_seen  <= sensor_command;
      st_addr_seen <= sensor_address;
    end
    if (tx_start) begin
      tx_cnt      <= tx_cnt + 1;
      tx_cyc      <= cyc;
      tx_cmd_seen <= tx_command;
      tx_val_seen <= tx_value;
    end
  end

  // uart_tx stand-in: busy from the cycle after tx_start for 4 cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_start) begin
        @(posedge clock); #1 tx_busy = 1'b1;
        repeat (4) @(posedge clock);
        #1 tx_busy = 1'b0;
      end
    end
  end

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] c, input logic [7:0] a, output int at);
    rx_command = c; rx_address = a; rx_valid = 1'b1; at = cyc;
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [7:0] c, input logic [7:0] v);
    sensor_resp_command = c; sensor_resp_value = v; sensor_done = 1'b1;
    step(1);
    sensor_done = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int limit);
    int s0; int k;
    s0 = start_cnt; k = 0;
    while (start_cnt == s0 && k < limit) begin step(1); k++; end
    check_eq({tag, "_seen"}, start_cnt - s0, 1);
  endtask

  task automatic wait_tx(input string tag, input int limit);
    int t0; int k;
    t0 = tx_cnt; k = 0;
    while (tx_cnt == t0 && k < limit) begin step(1); k++; end
    check_eq({tag, "_seen"}, tx_cnt - t0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t, s, d, tx0, s2, prev;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_command = '0; rx_address = '0;
    cancel_monitoring = 1'b0; sensor_done = 1'b0;
    sensor_resp_command = '0; sensor_resp_value = '0;
    step(3);
    check_eq("rst_flags", {sensor_start, tx_start, monitoring_active, overflow}, 0);
    check_eq("rst_buses", {sensor_command, sensor_address, tx_command, tx_value}, 0);
    reset = 1'b0;
    step(2);

    // T1: PC read answered 2 cycles after sensor_start
    tx0 = tx_cnt;
    send_rx(8'h01, 8'h00, t);
    wait_start("t1_start", 20);
    check_eq("t1_latency", start_cyc - t, 2);
    check_eq("t1_sensor_bus", {st_cmd_seen, st_addr_seen}, 16'h0100);
    step(1);
    d = cyc;
    pulse_done(8'h01, 8'h1B);
    wait_tx("t1_tx", 50);
    check_eq("t1_tx_delay", tx_cyc - d, 1);
    check_eq("t1_tx_bus", {tx_cmd_seen, tx_val_seen}, 16'h011B);
    step(15);
    check_eq("t1_tx_count", tx_cnt - tx0, 1);

    // T2: no response -> timeout exactly TMO cycles after sensor_start
    send_rx(8'h02, 8'h00, t);
    wait_start("t2_start", 20);
    s = start_cyc;
    wait_tx("t2_tx", 100);
    check_eq("t2_tmo_delay", tx_cyc - s, TMO);
    check_eq("t2_tx_bus", {tx_cmd_seen, tx_val_seen}, 16'hFE00);
    step(15);

    // sensor_done on the last timeout cycle wins over expiry
    tx0 = tx_cnt;
    send_rx(8'h01, 8'h09, t);
    wait_start("t2b_start", 20);
    check_eq("t2b_latency", start_cyc - t, 2);
    s = start_cyc;
    step(TMO - 2);
    pulse_done(8'h01, 8'h33);
    wait_tx("t2b_tx", 50);
    check_eq("t2b_tx_delay", tx_cyc - s, TMO);
    check_eq("t2b_tx_bus", {tx_cmd_seen, tx_val_seen}, 16'h0133);
    step(15);
    check_eq("t2b_tx_count", tx_cnt - tx0, 1);

    // T4: two requests during WAIT_SENSOR; first queued, second dropped
    send_rx(8'h01, 8'h03, t);
    wait_start("t4_start", 20);
    send_rx(8'h02, 8'h05, t);
    check_eq("t4_no_ovf", overflow, 0);
    send_rx(8'h01, 8'h07, t);
    check_eq("t4_ovf", overflow, 1);
    pulse_done(8'h01, 8'h22);
    wait_tx("t4_tx1", 50);
    check_eq("t4_tx1_bus", {tx_cmd_seen, tx_val_seen}, 16'h0122);
    wait_start("t4_queued", 50);
    check_eq("t4_queued_bus", {st_cmd_seen, st_addr_seen}, 16'h0205);
    s2 = start_cnt;
    step(1);
    pulse_done(8'h02, 8'h44);
    wait_tx("t4_tx2", 50);
    check_eq("t4_tx2_bus", {tx_cmd_seen, tx_val_seen}, 16'h0244);
    step(40);
    check_eq("t4_dropped", start_cnt - s2, 0);
    check_eq("t4_ovf_sticky", overflow, 1);

    // T3/T6: MON_TEMP, immediate read then one per PERIOD; samples 15,15,16
    tx0 = tx_cnt;
    send_rx(8'h03, 8'h00, t);
    wait_start("t3_first", 20);
    check_eq("t3_latency", start_cyc - t, 2);
    check_eq("t3_first_bus", {st_cmd_seen, st_addr_seen}, 16'h0100);
    check_eq("t3_mon_on", monitoring_active, 1);
    prev = start_cyc;
    step(1);
    pulse_done(8'h01, 8'h15);
    for (int i = 0; i < 2; i++) begin
      wait_start("t3_periodic", 200);
      check_eq("t3_interval", start_cyc - prev, PERIOD);
      check_eq("t3_periodic_bus", {st_cmd_seen, st_addr_seen}, 16'h0100);
      prev = start_cyc;
      step(1);
      pulse_done(8'h01, (i == 0) ? 8'h15 : 8'h16);
    end
    step(20);
`ifdef MON_CHANGE_ONLY_EN
    check_eq("t3_tx_count", tx_cnt - tx0, 2);
`else
    check_eq("t3_tx_count", tx_cnt - tx0, 3);
`endif
    check_eq("t3_last_tx", {tx_cmd_seen, tx_val_seen}, 16'h0116);
    cancel_monitoring = 1'b1;
    step(1);
    cancel_monitoring = 1'b0;
    check_eq("t3_mon_off", monitoring_active, 0);
    s2 = start_cnt;
    step(250);
    check_eq("t3_no_more_reads", start_cnt - s2, 0);

    // mon start accepted in the same cycle as cancel: read happens, monitoring stays off
    send_rx(8'h04, 8'h01, t);
    cancel_monitoring = 1'b1;
    step(1);
    cancel_monitoring = 1'b0;
    check_eq("cc_mon_off", monitoring_active, 0);
    wait_start("cc_start", 20);
    check_eq("cc_bus", {st_cmd_seen, st_addr_seen}, 16'h0201);
    step(1);
    pulse_done(8'h02, 8'h55);
    wait_tx("cc_tx", 50);
    check_eq("cc_tx_bus", {tx_cmd_seen, tx_val_seen}, 16'h0255);
    s2 = start_cnt;
    step(250);
    check_eq("cc_no_more_reads", start_cnt - s2, 0);

    // T5: tick and PC request pending together -> PC first, mon read next
    send_rx(8'h04, 8'h02, t);
    wait_start("t5_mon", 20);
    s = start_cyc;
    step(1);
    pulse_done(8'h02, 8'h60);
    while (cyc < s + PERIOD - 2) step(1);
    send_rx(8'h01, 8'h04, t);
    wait_start("t5_pc", 20);
    check_eq("t5_pc_bus", {st_cmd_seen, st_addr_seen}, 16'h0104);
    check_eq("t5_pc_cycle", start_cyc - s, PERIOD);
    step(1);
    pulse_done(8'h01, 8'h70);
    wait_start("t5_mon2", 50);
    check_eq("t5_mon2_bus", {st_cmd_seen, st_addr_seen}, 16'h0202);
    step(1);
    pulse_done(8'h02, 8'h61);
    step(20);
    s2 = start_cnt;
    send_rx(8'h05, 8'h02, t);
    wait_tx("t5_stop", 20);
    check_eq("t5_stop_delay", tx_cyc - t, 2);
    check_eq("t5_stop_bus", {tx_cmd_seen, tx_val_seen}, 16'h0A02);
    check_eq("t5_mon_off", monitoring_active, 0);
    step(150);
    check_eq("t5_no_sensor_access", start_cnt - s2, 0);

    // reset mid-transaction abandons it and clears overflow
    send_rx(8'h01, 8'h00, t);
    wait_start("rm_start", 20);
    step(1);
    reset = 1'b1;
    step(2);
    check_eq("rm_flags", {sensor_start, tx_start, monitoring_active, overflow}, 0);
    check_eq("rm_buses", {sensor_command, sensor_address, tx_command, tx_value}, 0);
    reset = 1'b0;
    tx0 = tx_cnt;
    step(60);
    check_eq("rm_no_tx", tx_cnt - tx0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
